// File: rtl/sdr_access_sched.sv
// sdr_access_sched: round-robin host arbiter with periodic auto-refresh in front of the SDR command FSM.
// Optional macro SDR_REF_POSTPONE_EN lets host traffic defer up to MAX_POSTPONE refreshes.
module sdr_access_sched #(
   parameter int NUM_REQ      = 2,
   parameter int REF_INTERVAL = 780,
   parameter int REF_CNT_W    = 12,
   parameter int MAX_POSTPONE = 4
) (
   input  logic                       pclk,
   input  logic                       preset,
   input  logic                       init_done,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ-1:0]         req_write,
   output logic [NUM_REQ-1:0]         gnt,
   output logic                       cmd_start,
   output logic                       cmd_write,
   output logic                       cmd_ref,
   input  logic                       cmd_done,
   output logic [$clog2(NUM_REQ)-1:0] owner,
   output logic                       busy,
   output logic                       ref_pending,
   output logic                       ref_overdue
);
   localparam int OW = $clog2(NUM_REQ);
   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] WAIT_CMD = 2'd1;
   localparam logic [1:0] WAIT_REF = 2'd2;
`ifdef SDR_REF_POSTPONE_EN
   localparam logic [2:0] SAT = 3'(MAX_POSTPONE);
`else
   localparam logic [2:0] SAT = 3'(MAX_POSTPONE > 0);
`endif
   logic [1:0]           state;
   logic [REF_CNT_W-1:0] ref_cnt;
   logic [2:0]           dcnt;
   logic [OW-1:0]        ptr;
   logic [OW-1:0]        win;
   logic                 expire;
   logic                 ref_sel;
   logic                 issue_ref;
   logic                 issue_host;
   assign expire = init_done && ref_cnt == REF_CNT_W'(REF_INTERVAL - 1);
`ifdef SDR_REF_POSTPONE_EN
   assign ref_sel = dcnt == SAT || (dcnt != 3'd0 && req == '0);
`else
   assign ref_sel = dcnt != 3'd0;
`endif
   assign issue_ref   = state == IDLE && init_done && ref_sel;
   assign issue_host  = state == IDLE && init_done && !ref_sel && |req;
   assign ref_pending = dcnt != 3'd0;
   // Scan downward so the last hit is the first requester after ptr.
   always_comb begin
      win = '0;
      for (int i = NUM_REQ; i >= 1; i--)
         if (req[OW'((int'(ptr) + i) % NUM_REQ)]) win = OW'((int'(ptr) + i) % NUM_REQ);
   end
   always_ff @(posedge pclk) begin
      if (preset || !init_done) ref_cnt <= '0;
      else ref_cnt <= expire ? '0 : ref_cnt + REF_CNT_W'(1);
   end
   always_ff @(posedge pclk) begin
      if (preset) begin
         dcnt        <= 3'd0;
         ref_overdue <= 1'b0;
      end else if (expire && !issue_ref) begin
         if (dcnt == SAT) ref_overdue <= 1'b1;
         else dcnt <= dcnt + 3'd1;
      end else if (issue_ref && !expire) begin
         dcnt <= dcnt - 3'd1;
      end
   end
   always_ff @(posedge pclk) begin
      if (preset) begin
         state     <= IDLE;
         gnt       <= '0;
         cmd_start <= 1'b0;
         cmd_write <= 1'b0;
         cmd_ref   <= 1'b0;
         owner     <= '0;
         busy      <= 1'b0;
         ptr       <= OW'(NUM_REQ - 1);
      end else begin
         gnt       <= '0;
         cmd_start <= 1'b0;
         cmd_ref   <= 1'b0;
         if (issue_ref) begin
            cmd_ref <= 1'b1;
            busy    <= 1'b1;
            state   <= WAIT_REF;
         end else if (issue_host) begin
            gnt       <= NUM_REQ'(1) << win;
            cmd_start <= 1'b1;
            cmd_write <= req_write[win];
            owner     <= win;
            ptr       <= win;
            busy      <= 1'b1;
            state     <= WAIT_CMD;
         end else if (state != IDLE && cmd_done) begin
            busy  <= 1'b0;
            state <= IDLE;
         end
      end
   end
endmodule
